// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter: FSM states, write-port
// bundles and the scoreboard address-mask helper.
package regfile_wb_arbiter_pkg;

    localparam int WB_XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } wb_arb_state_t;

    typedef struct packed {
        logic               wren;
        logic [4:0]         waddr;
        logic [WB_XLEN-1:0] wdata;
    } register_in_type;

    // Both requesters share the write-field layout; wren doubles as pipe_wren / mc_valid.
    typedef struct packed {
        register_in_type pipe;
        register_in_type mc;
    } wb_arb_in_type;

    typedef struct packed {
        logic pipe_hold;
        logic mc_ready;
    } wb_arb_out_type;

    // One-hot scoreboard mask; x0 is never tracked.
    function automatic logic [31:0] addr_mask(input logic [4:0] addr);
        addr_mask = (addr == 5'd0) ? 32'd0 : (32'd1 << addr);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of pipeline, multicycle, decode and register-file write signals
// around the writeback arbiter.
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
    #(parameter int XLEN = WB_XLEN) ();

    logic            pipe_wren;
    logic [4:0]      pipe_waddr;
    logic [XLEN-1:0] pipe_wdata;
    logic            pipe_hold;
    logic            mc_issue;
    logic [4:0]      mc_issue_addr;
    logic            mc_valid;
    logic [4:0]      mc_waddr;
    logic [XLEN-1:0] mc_wdata;
    logic            mc_ready;
    logic            dec_rden1;
    logic            dec_rden2;
    logic [4:0]      dec_raddr1;
    logic [4:0]      dec_raddr2;
    logic            dec_wren;
    logic [4:0]      dec_waddr;
    logic            hazard;
    logic            wren;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;
    logic [31:0]     pending;

    modport master (
        output pipe_wren, pipe_waddr, pipe_wdata,
        output mc_issue, mc_issue_addr, mc_valid, mc_waddr, mc_wdata,
        output dec_rden1, dec_rden2, dec_raddr1, dec_raddr2, dec_wren, dec_waddr,
        input  pipe_hold, mc_ready, hazard, wren, waddr, wdata, pending
    );

    modport slave (
        input  pipe_wren, pipe_waddr, pipe_wdata,
        input  mc_issue, mc_issue_addr, mc_valid, mc_waddr, mc_wdata,
        input  dec_rden1, dec_rden2, dec_raddr1, dec_raddr2, dec_wren, dec_waddr,
        output pipe_hold, mc_ready, hazard, wren, waddr, wdata, pending
    );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-destination scoreboard for multicycle ops and the decode hazard check.
module regfile_wb_arbiter_scoreboard
    import regfile_wb_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        set_en,
    input  logic [4:0]  set_addr,
    input  logic        clr_en,
    input  logic [4:0]  clr_addr,
    input  logic        dec_rden1,
    input  logic [4:0]  dec_raddr1,
    input  logic        dec_rden2,
    input  logic [4:0]  dec_raddr2,
    input  logic        dec_wren,
    input  logic [4:0]  dec_waddr,
    output logic [31:0] pending,
    output logic        hazard
);

    logic [31:0] pending_r;
    logic [31:0] set_mask_s;
    logic [31:0] clr_mask_s;

    assign set_mask_s = set_en ? addr_mask(set_addr) : 32'd0;
    assign clr_mask_s = clr_en ? addr_mask(clr_addr) : 32'd0;

    // Clear first, then OR in the new issue so a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_r <= 32'd0;
        end else begin
            pending_r <= (pending_r & ~clr_mask_s) | set_mask_s;
        end
    end

    // Bit 0 is never set, so x0 sources/destinations cannot hazard.
    always_comb begin
        hazard = (dec_rden1 & pending_r[dec_raddr1])
               | (dec_rden2 & pending_r[dec_raddr2])
               | (dec_wren  & pending_r[dec_waddr]);
    end

    assign pending = pending_r;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between pipeline writeback and a
// multicycle unit, with bounded starvation and a pending-register scoreboard.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    wb_arb_state_t   state_r;
    wb_arb_state_t   next_state_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_next_s;
    logic [CW-1:0]   cnt_inc_s;
    logic            grant_pipe_s;
    logic            grant_mc_s;
    wb_arb_in_type   in_s;
    wb_arb_out_type  out_s;
    register_in_type wr_r;

    assign in_s.pipe = '{wren: bus.pipe_wren, waddr: bus.pipe_waddr, wdata: bus.pipe_wdata};
    assign in_s.mc   = '{wren: bus.mc_valid,  waddr: bus.mc_waddr,   wdata: bus.mc_wdata};

    // FSM state and starvation counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
        end
    end

    assign cnt_inc_s = (state_r == IDLE) ? CW'(1) : (cnt_r + CW'(1));

    // Arbitration: pipeline first, until the multicycle unit has been refused MAX_WAIT times.
    always_comb begin
        next_state_s    = IDLE;
        cnt_next_s      = '0;
        grant_pipe_s    = 1'b0;
        grant_mc_s      = 1'b0;
        out_s.pipe_hold = 1'b0;
        case (state_r)
            IDLE, WAIT: begin
                if (in_s.pipe.wren) begin
                    grant_pipe_s = 1'b1;
                    if (in_s.mc.wren) begin
                        if (cnt_inc_s >= CW'(MAX_WAIT)) begin
                            next_state_s = FORCE;
                            cnt_next_s   = cnt_inc_s;
                        end else begin
                            next_state_s = WAIT;
                            cnt_next_s   = cnt_inc_s;
                        end
                    end else begin
                        next_state_s = IDLE;
                    end
                end else if (in_s.mc.wren) begin
                    grant_mc_s = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            FORCE: begin
                out_s.pipe_hold = 1'b1;
                if (in_s.mc.wren) begin
                    grant_mc_s = 1'b1;
                end else begin
                    grant_mc_s = 1'b0;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // A result offered while in reset is not accepted; its producer re-presents it.
    assign out_s.mc_ready = grant_mc_s & rst;

    // Registered write port; x0 grants are consumed but never write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_r <= '0;
        end else if (grant_pipe_s) begin
            wr_r <= '{wren: (in_s.pipe.waddr != 5'd0), waddr: in_s.pipe.waddr, wdata: in_s.pipe.wdata};
        end else if (grant_mc_s) begin
            wr_r <= '{wren: (in_s.mc.waddr != 5'd0), waddr: in_s.mc.waddr, wdata: in_s.mc.wdata};
        end else begin
            wr_r.wren <= 1'b0;
        end
    end

    regfile_wb_arbiter_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en     (bus.mc_issue),
        .set_addr   (bus.mc_issue_addr),
        .clr_en     (out_s.mc_ready),
        .clr_addr   (bus.mc_waddr),
        .dec_rden1  (bus.dec_rden1),
        .dec_raddr1 (bus.dec_raddr1),
        .dec_rden2  (bus.dec_rden2),
        .dec_raddr2 (bus.dec_raddr2),
        .dec_wren   (bus.dec_wren),
        .dec_waddr  (bus.dec_waddr),
        .pending    (bus.pending),
        .hazard     (bus.hazard)
    );

    assign bus.pipe_hold = out_s.pipe_hold;
    assign bus.mc_ready  = out_s.mc_ready;
    assign bus.wren      = wr_r.wren;
    assign bus.waddr     = wr_r.waddr;
    assign bus.wdata     = wr_r.wdata;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed-vector bench for regfile_wb_arbiter: reset, solo writes, contention,
// scoreboard hazards, set/clear collision and mid-operation reset.
module tb_regfile_wb_arbiter;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.MAX_WAIT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one cycle; afterwards registered outputs show the previous cycle's grant.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.pipe_wren     = 1'b0;
        bus.pipe_waddr    = 5'd0;
        bus.pipe_wdata    = 32'd0;
        bus.mc_issue      = 1'b0;
        bus.mc_issue_addr = 5'd0;
        bus.mc_valid      = 1'b0;
        bus.mc_waddr      = 5'd0;
        bus.mc_wdata      = 32'd0;
        bus.dec_rden1     = 1'b0;
        bus.dec_rden2     = 1'b0;
        bus.dec_raddr1    = 5'd0;
        bus.dec_raddr2    = 5'd0;
        bus.dec_wren      = 1'b0;
        bus.dec_waddr     = 5'd0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        clear_inputs();

        // Reset with both requesters active.
        bus.pipe_wren  = 1'b1;
        bus.pipe_waddr = 5'd3;
        bus.pipe_wdata = 32'h0000_0033;
        bus.mc_valid   = 1'b1;
        bus.mc_waddr   = 5'd2;
        bus.mc_wdata   = 32'h0000_0022;
        tick(); tick(); tick();
        check_val("rst_wren", {31'd0, bus.wren}, 32'd0);
        check_val("rst_pending", bus.pending, 32'd0);
        check_val("rst_mc_ready", {31'd0, bus.mc_ready}, 32'd0);
        check_val("rst_waddr", {27'd0, bus.waddr}, 32'd0);
        rst = 1'b1;
        clear_inputs();
        #1;
        check_val("rel_mc_ready", {31'd0, bus.mc_ready}, 32'd0);
        tick();
        check_val("rel_wren", {31'd0, bus.wren}, 32'd0);

        // Solo pipeline write, then an x0 write.
        bus.pipe_wren  = 1'b1;
        bus.pipe_waddr = 5'd5;
        bus.pipe_wdata = 32'hDEAD_BEEF;
        #1;
        check_val("pipe_hold_idle", {31'd0, bus.pipe_hold}, 32'd0);
        tick();
        check_val("pipe_wren", {31'd0, bus.wren}, 32'd1);
        check_val("pipe_waddr", {27'd0, bus.waddr}, 32'd5);
        check_val("pipe_wdata", bus.wdata, 32'hDEAD_BEEF);
        bus.pipe_waddr = 5'd0;
        bus.pipe_wdata = 32'h0000_1234;
        tick();
        check_val("x0_wren", {31'd0, bus.wren}, 32'd0);
        clear_inputs();

        // Solo multicycle write.
        bus.mc_valid = 1'b1;
        bus.mc_waddr = 5'd12;
        bus.mc_wdata = 32'hA5A5_0012;
        #1;
        check_val("mc_solo_ready", {31'd0, bus.mc_ready}, 32'd1);
        tick();
        clear_inputs();
        check_val("mc_solo_wren", {31'd0, bus.wren}, 32'd1);
        check_val("mc_solo_waddr", {27'd0, bus.waddr}, 32'd12);
        check_val("mc_solo_wdata", bus.wdata, 32'hA5A5_0012);

        // Contention: three refusals, then the forced yield.
        bus.pipe_wren  = 1'b1;
        bus.pipe_waddr = 5'd6;
        bus.pipe_wdata = 32'h1111_1111;
        bus.mc_valid   = 1'b1;
        bus.mc_waddr   = 5'd7;
        bus.mc_wdata   = 32'h7777_7777;
        #1;
        check_val("cont_ready_1", {31'd0, bus.mc_ready}, 32'd0);
        tick();
        check_val("cont_ready_2", {31'd0, bus.mc_ready}, 32'd0);
        check_val("cont_pipe_waddr", {27'd0, bus.waddr}, 32'd6);
        tick();
        check_val("cont_ready_3", {31'd0, bus.mc_ready}, 32'd0);
        check_val("cont_hold_3", {31'd0, bus.pipe_hold}, 32'd0);
        tick();
        check_val("force_hold", {31'd0, bus.pipe_hold}, 32'd1);
        check_val("force_ready", {31'd0, bus.mc_ready}, 32'd1);
        tick();
        bus.mc_valid = 1'b0;
        check_val("force_wren", {31'd0, bus.wren}, 32'd1);
        check_val("force_waddr", {27'd0, bus.waddr}, 32'd7);
        check_val("force_wdata", bus.wdata, 32'h7777_7777);
        check_val("after_force_hold", {31'd0, bus.pipe_hold}, 32'd0);
        tick();
        bus.pipe_wren = 1'b0;
        check_val("resume_waddr", {27'd0, bus.waddr}, 32'd6);
        check_val("resume_wdata", bus.wdata, 32'h1111_1111);
        tick();
        clear_inputs();
        check_val("idle_wren", {31'd0, bus.wren}, 32'd0);

        // Scoreboard and hazard.
        bus.mc_issue      = 1'b1;
        bus.mc_issue_addr = 5'd9;
        bus.dec_rden1     = 1'b1;
        bus.dec_raddr1    = 5'd9;
        #1;
        check_val("haz_issue_cycle", {31'd0, bus.hazard}, 32'd0);
        tick();
        bus.mc_issue = 1'b0;
        #1;
        check_val("sb_pending9", bus.pending, 32'h0000_0200);
        check_val("haz_rs1", {31'd0, bus.hazard}, 32'd1);
        bus.dec_rden1 = 1'b0;
        bus.dec_wren  = 1'b1;
        bus.dec_waddr = 5'd9;
        #1;
        check_val("haz_rd", {31'd0, bus.hazard}, 32'd1);
        bus.dec_wren   = 1'b0;
        bus.dec_rden2  = 1'b1;
        bus.dec_raddr2 = 5'd0;
        #1;
        check_val("haz_x0", {31'd0, bus.hazard}, 32'd0);
        bus.dec_rden2  = 1'b0;
        bus.dec_rden1  = 1'b1;
        bus.mc_valid   = 1'b1;
        bus.mc_waddr   = 5'd9;
        bus.mc_wdata   = 32'h0000_0999;
        #1;
        check_val("haz_grant_ready", {31'd0, bus.mc_ready}, 32'd1);
        check_val("haz_grant_cycle", {31'd0, bus.hazard}, 32'd1);
        tick();
        bus.mc_valid = 1'b0;
        #1;
        check_val("haz_cleared", {31'd0, bus.hazard}, 32'd0);
        check_val("sb_cleared", bus.pending, 32'd0);
        check_val("sb_wb_waddr", {27'd0, bus.waddr}, 32'd9);
        clear_inputs();

        // Same-cycle set and clear of x4: set wins.
        bus.mc_issue      = 1'b1;
        bus.mc_issue_addr = 5'd4;
        bus.mc_valid      = 1'b1;
        bus.mc_waddr      = 5'd4;
        bus.mc_wdata      = 32'h0000_0444;
        #1;
        check_val("coll_ready", {31'd0, bus.mc_ready}, 32'd1);
        tick();
        clear_inputs();
        check_val("coll_pending", bus.pending, 32'h0000_0010);

        // Reset taken while in FORCE.
        bus.pipe_wren  = 1'b1;
        bus.pipe_waddr = 5'd6;
        bus.pipe_wdata = 32'h6666_6666;
        bus.mc_valid   = 1'b1;
        bus.mc_waddr   = 5'd8;
        bus.mc_wdata   = 32'h8888_8888;
        tick(); tick(); tick();
        check_val("mr_force_hold", {31'd0, bus.pipe_hold}, 32'd1);
        rst = 1'b0;
        #1;
        check_val("mr_ready_gated", {31'd0, bus.mc_ready}, 32'd0);
        tick();
        check_val("mr_hold", {31'd0, bus.pipe_hold}, 32'd0);
        check_val("mr_wren", {31'd0, bus.wren}, 32'd0);
        check_val("mr_pending", bus.pending, 32'd0);
        rst = 1'b1;
        clear_inputs();
        tick();
        check_val("mr_post_wren", {31'd0, bus.wren}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
